// File: rtl/matrix_pkg.sv
// matrix_pkg: MAX7219 register map, display geometry and scroll FSM states
package matrix_pkg;

    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIM   = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam int NUM_MODULES = 4;
    localparam int ROWS        = 8;
    localparam int VIS_COLS    = 32;

    typedef enum logic [1:0] {INIT_SEND, WAIT_TICK, BUILD, SEND} scroll_state_t;

    // Message contents: column c shows the bit pattern of c
    function automatic logic [7:0] msg_col(input logic [7:0] c);
        return c;
    endfunction

    // Configuration word for row slot r of the init frame
    function automatic logic [15:0] init_word(input int r, input logic [3:0] intensity);
        return r == 0 ? {REG_DECODE, 8'h00} :
               r == 1 ? {REG_INTENSITY, 4'h0, intensity} :
               r == 2 ? {REG_SCANLIM, 8'h07} :
               r == 3 ? {REG_SHUTDOWN, 8'h01} :
               r == 4 ? {REG_TEST, 8'h00} : {REG_NOOP, 8'h00};
    endfunction

endpackage

// File: rtl/matrix_msg_rom.sv
// matrix_msg_rom: message column ROM with one-cycle registered read
module matrix_msg_rom import matrix_pkg::*; #(
    parameter int MSG_COLS = 64,
    parameter int AW = $clog2(MSG_COLS)
) (
    input  logic          clk_9m,
    input  logic [AW-1:0] addr,
    output logic [7:0]    col
);

    // Registered lookup of the addressed column byte
    always_ff @(posedge clk_9m)
        col <= msg_col(8'(addr));

endmodule

// File: rtl/matrix_scroll_pg.sv
// matrix_scroll_pg: builds scrolling 4x8x8 frames and hands them to the serial core
module matrix_scroll_pg import matrix_pkg::*; #(
    parameter int         TICK_DIV  = 900000,
    parameter int         MSG_COLS  = 64,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic                 clk_9m,
    input  logic                 rst,
    input  logic                 scroll_en,
    input  logic                 send_done,
    output logic                 en,
    output logic [ROWS-1:0][63:0] data
);

    localparam int AW = $clog2(MSG_COLS);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [5:0] LAST = 6'(VIS_COLS + 1);

    scroll_state_t state;
    logic [TW-1:0] tick_cnt;
    logic tick;
    logic pending;
    logic [AW-1:0] offset;
    logic [AW-1:0] rom_addr;
    logic [AW:0] sum;
    logic [5:0] cnt;
    logic [4:0] k;
    logic [7:0] rom_col;
    logic [VIS_COLS-1:0] stage [ROWS];
    logic [ROWS-1:0][63:0] frame;
    logic [ROWS-1:0][63:0] init_frame;

    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    assign sum = (AW+1)'(offset) + (AW+1)'(cnt);
    assign rom_addr = AW'(sum >= (AW+1)'(MSG_COLS) ? sum - (AW+1)'(MSG_COLS) : sum);
    assign k = 5'(cnt - 6'd1);

    matrix_msg_rom #(.MSG_COLS(MSG_COLS)) rom (
        .clk_9m (clk_9m),
        .addr   (rom_addr),
        .col    (rom_col)
    );

    // Assemble the config frame and the image frame (row address byte + staged pixels)
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            for (int m = 0; m < NUM_MODULES; m++) begin
                init_frame[r][16*m +: 16] = init_word(r, INTENSITY);
                frame[r][16*m +: 16] = {8'(r + 1), stage[r][8*m +: 8]};
            end
    end

    // Free-running scroll tick divider
    always_ff @(posedge clk_9m or posedge rst)
        if (rst) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

    // Stage returned columns; column k lands at bit k^7 so each module byte is msb-left
    always_ff @(posedge clk_9m)
        if (state == BUILD && cnt != 6'd0 && cnt <= 6'(VIS_COLS))
            for (int r = 0; r < ROWS; r++)
                stage[r][{k[4:3], ~k[2:0]}] <= rom_col[r];

    // Frame sequencing: init frame, then tick-paced build/send with one-deep tick pending
    always_ff @(posedge clk_9m or posedge rst)
        if (rst) begin
            state   <= INIT_SEND;
            en      <= 1'b0;
            data    <= '0;
            offset  <= '0;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            if (tick && state != WAIT_TICK) pending <= 1'b1;
            case (state)
                INIT_SEND:
                    if (!en) begin
                        en   <= 1'b1;
                        data <= init_frame;
                    end else if (send_done) begin
                        en    <= 1'b0;
                        state <= WAIT_TICK;
                    end
                WAIT_TICK:
                    if (tick || pending) begin
                        pending <= 1'b0;
                        cnt     <= '0;
                        state   <= BUILD;
                    end
                BUILD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        data  <= frame;
                        en    <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND:
                    if (send_done) begin
                        en <= 1'b0;
                        if (scroll_en) offset <= offset == AW'(MSG_COLS - 1) ? '0 : offset + 1'b1;
                        state <= WAIT_TICK;
                    end
                default: state <= INIT_SEND;
            endcase
        end

endmodule
